// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing one UDP/IP transmit engine between two packet sources,
// with an enforced inter-frame gap and a per-frame watchdog.
module eth_tx_arbiter #(
  parameter int IFG_CYCLES     = 24,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0,
  input  logic [15:0] num0,
  input  logic [31:0] data0,
  output logic        rd0,
  output logic        done0,
  input  logic        req1,
  input  logic [15:0] num1,
  input  logic [31:0] data1,
  output logic        rd1,
  output logic        done1,
  output logic        eng_send_en,
  output logic [15:0] eng_send_data_num,
  output logic [31:0] eng_send_data,
  input  logic        eng_read_data_req,
  input  logic        eng_send_end,
  output logic        busy,
  output logic        grant_id,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_last;
  logic [15:0]      r_num;
  logic             r_send_en;
  logic             r_done0;
  logic             r_done1;
  logic             r_tmo;
  logic [CNT_W-1:0] r_wdog;
  logic [CNT_W-1:0] r_gap;

  logic w_v0, w_v1, w_win, w_in_busy;

  // A zero-length request is treated as no request at all.
  assign w_v0  = req0 && (num0 != 16'd0);
  assign w_v1  = req1 && (num1 != 16'd0);
  assign w_win = (w_v0 && w_v1) ? ~r_last : w_v1;
  assign w_in_busy = (r_state == S_BUSY);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_num     <= 16'd0;
      r_send_en <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_tmo     <= 1'b0;
      r_wdog    <= '0;
      r_gap     <= '0;
    end else begin
      r_send_en <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_tmo     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_v0 || w_v1) begin
            r_grant   <= w_win;
            r_num     <= w_win ? num1 : num0;
            r_send_en <= 1'b1;
            r_wdog    <= '0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_wdog <= r_wdog + 1'b1;
          // Frame completion wins over a watchdog expiry on the same edge.
          if (eng_send_end) begin
            if (r_grant) r_done1 <= 1'b1;
            else         r_done0 <= 1'b1;
            r_last  <= r_grant;
            r_gap   <= '0;
            r_state <= S_GAP;
          end else if (r_wdog == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_tmo   <= 1'b1;
            r_last  <= r_grant;
            r_gap   <= '0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == CNT_W'(IFG_CYCLES - 1)) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy              = (r_state != S_IDLE);
  assign grant_id          = r_grant;
  assign eng_send_en       = r_send_en;
  assign eng_send_data_num = r_num;
  assign done0             = r_done0;
  assign done1             = r_done1;
  assign timeout_err       = r_tmo;
  assign rd0               = w_in_busy && !r_grant && eng_read_data_req;
  assign rd1               = w_in_busy &&  r_grant && eng_read_data_req;
  assign eng_send_data     = w_in_busy ? (r_grant ? data1 : data0) : 32'd0;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed table, multi-cycle corner
// sequences, and randomized traffic against a timestamp-based frame model.
module tb_eth_tx_arbiter;
  localparam int IFG = 24;
  localparam int TMO = 4096;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] num0 = '0, num1 = '0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        eng_read_data_req = 1'b0, eng_send_end = 1'b0;
  logic        rd0, rd1, done0, done1, eng_send_en, busy, grant_id, timeout_err;
  logic [15:0] eng_send_data_num;
  logic [31:0] eng_send_data;

  eth_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0(req0), .num0(num0), .data0(data0), .rd0(rd0), .done0(done0),
    .req1(req1), .num1(num1), .data1(data1), .rd1(rd1), .done1(done1),
    .eng_send_en(eng_send_en), .eng_send_data_num(eng_send_data_num),
    .eng_send_data(eng_send_data), .eng_read_data_req(eng_read_data_req),
    .eng_send_end(eng_send_end), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame-level reference: each frame is described by the edge it was granted on,
  // the edge it ended on, and the edge its gap expires; pulses are keyed by edge number.
  int   cyc = 0;
  bit   m_valid = 0;
  int   m_mode = 0;   // 0 idle, 1 frame in flight, 2 gap
  int   m_start = 0, m_gap_end = 0;
  int   en_e = -1, d0_e = -1, d1_e = -1, to_e = -1;
  bit   m_grant = 0, m_last = 1;
  logic [15:0] m_num = '0;

  task automatic model_edge();
    bit v0, v1, w;
    cyc++;
    if (sys_rst) begin
      m_valid = 1; m_mode = 0; m_grant = 0; m_last = 1; m_num = '0;
      en_e = -1; d0_e = -1; d1_e = -1; to_e = -1;
      return;
    end
    if (!m_valid) return;
    case (m_mode)
      0: begin
        v0 = req0 && num0 != 0;
        v1 = req1 && num1 != 0;
        if (v0 || v1) begin
          w = (v0 && v1) ? !m_last : v1;
          m_grant = w; m_num = w ? num1 : num0;
          en_e = cyc; m_start = cyc; m_mode = 1;
        end
      end
      1: begin
        if (eng_send_end) begin
          if (m_grant) d1_e = cyc; else d0_e = cyc;
          m_last = m_grant; m_gap_end = cyc + IFG; m_mode = 2;
        end else if (cyc - m_start == TMO) begin
          to_e = cyc; m_last = m_grant; m_gap_end = cyc + IFG; m_mode = 2;
        end
      end
      default: if (cyc == m_gap_end) m_mode = 0;
    endcase
  endtask

  function automatic logic [55:0] model_out();
    bit f = (m_mode == 1);
    logic [31:0] d = f ? (m_grant ? data1 : data0) : 32'd0;
    return {m_mode != 0, m_grant, en_e == cyc, d0_e == cyc, d1_e == cyc, to_e == cyc,
            f && !m_grant && eng_read_data_req, f && m_grant && eng_read_data_req, m_num, d};
  endfunction

  // Called at a negedge with inputs already set; returns at the following negedge.
  task automatic tick();
    #1;
    if (m_valid)
      chk("cycle_model", {8'h0, busy, grant_id, eng_send_en, done0, done1, timeout_err, rd0, rd1,
                          eng_send_data_num, eng_send_data}, {8'h0, model_out()});
    @(posedge sys_clk);
    model_edge();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst = 1; req0 = 0; req1 = 0; num0 = 0; num1 = 0;
    eng_send_end = 0; eng_read_data_req = 0;
    tick(); tick();
    sys_rst = 0;
  endtask

  typedef struct {
    logic rst, r0; logic [15:0] n0; logic r1; logic [15:0] n1; logic fin; int reps;
    logic x_busy, x_en, x_grant, x_d0, x_d1; logic [15:0] x_num;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] words [3];
    int n, busy_cnt, d0_cnt, d1_seen;
    words[0] = 32'h68747470; words[1] = 32'h3a2f2f77; words[2] = 32'h77770000;

    //            rst r0 n0 r1 n1 fin reps  busy en gr d0 d1 num
    tbl.push_back('{1, 0,  0, 0,  0, 0, 2,   0, 0, 0, 0, 0, 16'd0});
    tbl.push_back('{0, 1,  0, 0,  0, 0, 3,   0, 0, 0, 0, 0, 16'd0});
    tbl.push_back('{0, 1, 10, 0,  0, 0, 1,   1, 1, 0, 0, 0, 16'd10});
    tbl.push_back('{0, 1, 10, 0,  0, 0, 1,   1, 0, 0, 0, 0, 16'd10});
    tbl.push_back('{0, 1, 10, 0,  0, 1, 1,   1, 0, 0, 1, 0, 16'd10});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 1,   1, 0, 0, 0, 0, 16'd10});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 22,  1, 0, 0, 0, 0, 16'd10});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 1,   0, 0, 0, 0, 0, 16'd10});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 1,   1, 1, 1, 0, 0, 16'd28});
    tbl.push_back('{0, 1, 10, 1, 28, 1, 1,   1, 0, 1, 0, 1, 16'd28});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 24,  0, 0, 1, 0, 0, 16'd28});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 1,   1, 1, 0, 0, 0, 16'd10});
    tbl.push_back('{1, 1, 10, 1, 28, 0, 1,   0, 0, 0, 0, 0, 16'd0});
    tbl.push_back('{0, 1, 10, 1, 28, 0, 1,   1, 1, 0, 0, 0, 16'd10});
    tbl.push_back('{1, 0,  0, 0,  0, 0, 1,   0, 0, 0, 0, 0, 16'd0});

    @(negedge sys_clk);
    foreach (tbl[i]) begin
      sys_rst = tbl[i].rst; req0 = tbl[i].r0; num0 = tbl[i].n0;
      req1 = tbl[i].r1; num1 = tbl[i].n1; eng_send_end = tbl[i].fin;
      for (int k = 0; k < tbl[i].reps; k++) tick();
      chk($sformatf("table_row%0d", i),
          {busy, eng_send_en, grant_id, done0, done1, eng_send_data_num},
          {tbl[i].x_busy, tbl[i].x_en, tbl[i].x_grant, tbl[i].x_d0, tbl[i].x_d1, tbl[i].x_num});
    end

    // Single frame from source 0, request dropped mid-frame, stray engine pulses in the gap.
    do_reset();
    req0 = 1; num0 = 10; data1 = 32'hdeadbeef;
    tick();
    chk("single_en", {eng_send_en, grant_id, eng_send_data_num}, {1'b1, 1'b0, 16'd10});
    req0 = 0;
    busy_cnt = 0; d0_cnt = 0; d1_seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      busy_cnt++;
      data0 = words[i % 3];
      eng_read_data_req = 1'($urandom_range(0, 1));
      eng_send_end = (i == 200) || (i > 205 && i < 210);
      tick();
      if (done0) d0_cnt++;
      if (done1 || rd1) d1_seen = 1;
    end
    chk("single_busy_len", busy_cnt, 225);
    chk("single_done_cnt", d0_cnt, 1);
    chk("single_no_src1", d1_seen, 0);

    // Idle: zero-length request and stray engine signals do nothing.
    req0 = 1; num0 = 0; eng_send_end = 1; eng_read_data_req = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("zero_len_idle", {busy, rd0, rd1, done0, done1, eng_send_en}, 6'b0);
    req0 = 0; eng_send_end = 0; eng_read_data_req = 0;

    // Watchdog on source 1, then source 0 pending is granted.
    do_reset();
    req1 = 1; num1 = 4;
    tick();
    chk("wdog_grant", {eng_send_en, grant_id, eng_send_data_num}, {1'b1, 1'b1, 16'd4});
    req0 = 1; num0 = 7;
    n = 0; d1_seen = 0;
    while (n < 5000 && !timeout_err) begin
      tick(); n++;
      if (done1) d1_seen = 1;
    end
    chk("wdog_latency", n, TMO);
    chk("wdog_no_done", d1_seen, 0);
    req1 = 0;
    n = 0;
    while (n < 100 && busy) begin tick(); n++; end
    chk("wdog_gap_len", n, IFG);
    tick();
    chk("wdog_next_src0", {eng_send_en, grant_id, eng_send_data_num}, {1'b1, 1'b0, 16'd7});

    // End arrives on the watchdog's final cycle: done wins, no timeout.
    req0 = 0;
    for (int i = 0; i < TMO - 1; i++) tick();
    eng_send_end = 1;
    tick();
    eng_send_end = 0;
    chk("coincide_done", {done0, timeout_err, busy}, 3'b101);

    // Randomized traffic against the frame model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        req0 = ~req0; num0 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1500));
      end
      if ($urandom_range(0, 15) == 0) begin
        req1 = ~req1; num1 = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1500));
      end
      data0 = $urandom; data1 = $urandom;
      eng_read_data_req = 1'($urandom_range(0, 1));
      eng_send_end = ($urandom_range(0, 63) == 0);
      sys_rst = ($urandom_range(0, 699) == 0);
      tick();
    end
    sys_rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
Shares the single UDP/IP transmit engine (the ip_send + crc32_d4 pair on the MII 4-bit tx clock) between two packet sources, e.g. the ARP responder and the UDP payload path. It arbitrates round-robin and issues the one-cycle send pulse and packet length to the engine. It routes the engine's data-read requests and payload words back to the granted source. It also enforces a minimum inter-frame gap and runs a watchdog on each frame.

Parameters:
IFG_CYCLES, 24, idle clock cycles inserted after each frame (96 bit times at 4 bits/clk)
TIMEOUT_CYCLES, 4096, max BUSY cycles allowed before the frame is abandoned
CNT_W, 16, width of the gap and watchdog counters

Ports:
sys_clk  in  1  tx clock, same as the engine clock
sys_rst  in  1  reset, synchronous, active-high
req0  in  1  source 0 request (level), held until done0 or timeout_err with grant_id=0
num0  in  16  source 0 payload byte count, stable while req0=1
data0  in  32  source 0 payload word
rd0  out  1  read strobe to source 0
done0  out  1  one-cycle pulse, source 0 frame completed
req1/num1/data1/rd1/done1  same as source 0, for source 1
eng_send_en  out  1  one-cycle start pulse to the engine
eng_send_data_num  out  16  latched byte count of the granted source
eng_send_data  out  32  payload word muxed from the granted source
eng_read_data_req  in  1  engine payload read request
eng_send_end  in  1  engine frame-complete pulse
busy  out  1  high in any state except IDLE
grant_id  out  1  index of the current or last granted source
timeout_err  out  1  one-cycle pulse when the watchdog expires

Behaviour:
- States: IDLE, BUSY, GAP.
- Reset values:
  - state=IDLE.
  - All outputs 0, including eng_send_data_num and grant_id.
  - last_grant=1, so source 0 wins the first tie.
  - Counters 0.
- Valid request: reqX=1 and numX!=0. A request with numX=0 is never granted and produces no done pulse.
- IDLE:
  - On an edge with at least one valid request, select the winner:
    - single valid request: that source;
    - both valid: the source != last_grant.
  - On that edge: grant_id<=winner, eng_send_data_num<=numX, eng_send_en<=1, state<=BUSY, watchdog<=0.
  - Latency: request sampled at edge N gives eng_send_en high for exactly the cycle after edge N.
- BUSY:
  - eng_send_en<=0.
  - eng_send_data = data[grant_id], combinational with zero latency.
  - rd[grant_id] = eng_read_data_req, combinational. The non-granted rd stays 0.
  - eng_send_data_num holds its value for the whole frame.
  - Watchdog increments every cycle.
  - If eng_send_end=1: done[grant_id]<=1 for one cycle, last_grant<=grant_id, gap counter<=0, state<=GAP.
  - Else if watchdog==TIMEOUT_CYCLES-1: timeout_err<=1 for one cycle, no done pulse, last_grant<=grant_id, state<=GAP.
  - eng_send_end has priority when it coincides with watchdog expiry.
- GAP:
  - rd0/rd1 are 0 and eng_read_data_req is ignored.
  - Gap counter increments each cycle.
  - When the counter reaches IFG_CYCLES-1, state<=IDLE.
  - Requests are not sampled in GAP, so frame starts are at least IFG_CYCLES+1 cycles after eng_send_end.
- Pulse outputs: done0/1, timeout_err and eng_send_en are registered pulses exactly one cycle wide.
- Stray engine signals: eng_send_end or eng_read_data_req outside BUSY are ignored and produce no outputs.
- Fairness: with both sources requesting continuously, grants strictly alternate.
- Request removal during BUSY: dropping req mid-frame does not abort the frame. It completes normally with a done pulse.
- Reset mid-frame: the next edge with sys_rst=1 forces IDLE and all outputs 0, and the frame is abandoned. The engine must be reset on the same reset.

Test Plan:
- Single request: req0=1, num0=10, data words 0x68747470/0x3a2f2f77/0x77770000; engine model returns eng_send_end after 200 cycles. Required: eng_send_en pulses 1 cycle after req0 is sampled; eng_send_data_num=10; rd0 mirrors eng_read_data_req with rd1=0; done0 pulses once; busy=1 for 1+200+24 cycles.
- Tie and alternation: req0 and req1 asserted together from reset and held, num0=10, num1=28. Required grant sequence 0,1,0,1; eng_send_data_num alternates 10/28; consecutive eng_send_en pulses are ≥25 cycles past the previous eng_send_end.
- Watchdog: engine never asserts eng_send_end; req1=1, num1=4. Required: timeout_err pulses exactly 4096 cycles after eng_send_en; no done1; IDLE reached after 24 gap cycles; req0 is granted next if pending.
- Stray and zero-length inputs: req0=1 with num0=0 gives no grant and busy stays 0. eng_send_end and eng_read_data_req pulses during IDLE/GAP produce no rd/done outputs.
- Reset mid-frame: sys_rst=1 for 1 cycle at BUSY cycle 50. Required: all outputs 0 on the next cycle and state=IDLE; after release with req0 and req1 both held, source 0 is granted first (last_grant reset to 1).
- Coincident events: eng_send_end arrives on the watchdog's final cycle. Required: done pulses, timeout_err stays 0.
